// File: rtl/sr_cmd_driver.sv
// Debounced push-button front end for an SR latch: turns clean presses into
// bounded s/r/enable pulses, never s=r=1, and mirrors the latched value.
module sr_cmd_driver #(
    parameter int DEB_CYCLES = 4,
    parameter int PULSE_LEN  = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_btn,
    input  logic reset_btn,
    output logic s,
    output logic r,
    output logic enable,
    output logic busy,
    output logic conflict,
    output logic q_mirror,
    output logic q_valid
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [7:0] DEB_LIM    = 8'(DEB_CYCLES);
    localparam logic [3:0] PULSE_LOAD = 4'(PULSE_LEN - 1);

    // Index 0 is the set button, index 1 the reset button.
    logic [1:0] btn_s;
    logic [1:0] sync1_q;
    logic [1:0] sync2_q;
    logic [1:0] deb_q;
    logic [1:0] deb_d;
    logic [1:0] deb_prev_q;
    logic [1:0] rise_s;
    logic [1:0] pend_q;
    logic [1:0] pend_d;
    logic [1:0] pend_clr_s;
    logic [7:0] cnt_q [2];
    logic [7:0] cnt_d [2];

    state_t     state_q;
    logic [3:0] pcnt_q;
    logic       cmd_set_q;
    logic       s_q;
    logic       r_q;
    logic       enable_q;
    logic       busy_q;
    logic       conflict_q;
    logic       q_mirror_q;
    logic       q_valid_q;

    assign btn_s = {reset_btn, set_btn};

    // Debounce next-state: the level flips only after DEB_CYCLES disagreeing samples.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            deb_d[i] = deb_q[i];
            cnt_d[i] = 8'd0;
            if (sync2_q[i] == deb_q[i]) begin
                cnt_d[i] = 8'd0;
            end else if ((cnt_q[i] + 8'd1) == DEB_LIM) begin
                deb_d[i] = sync2_q[i];
                cnt_d[i] = 8'd0;
            end else begin
                cnt_d[i] = cnt_q[i] + 8'd1;
            end
            rise_s[i] = deb_q[i] & ~deb_prev_q[i];
            // A new rise wins over a same-cycle clear so no press is lost.
            pend_d[i] = (pend_q[i] & ~pend_clr_s[i]) | rise_s[i];
        end
    end

    // Pending-flag consumption decided by the IDLE state.
    always_comb begin
        pend_clr_s = 2'b00;
        if (state_q == ST_IDLE) begin
            if (pend_q == 2'b11) begin
                pend_clr_s = 2'b11;
            end else if (pend_q[0]) begin
                pend_clr_s = 2'b01;
            end else if (pend_q[1]) begin
                pend_clr_s = 2'b10;
            end else begin
                pend_clr_s = 2'b00;
            end
        end else begin
            pend_clr_s = 2'b00;
        end
    end

    // Input path registers: synchroniser, debounce state, edge detect, pending flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q    <= 2'b00;
            sync2_q    <= 2'b00;
            deb_q      <= 2'b00;
            deb_prev_q <= 2'b00;
            pend_q     <= 2'b00;
            cnt_q[0]   <= 8'd0;
            cnt_q[1]   <= 8'd0;
        end else begin
            sync1_q    <= btn_s;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            pend_q     <= pend_d;
            cnt_q[0]   <= cnt_d[0];
            cnt_q[1]   <= cnt_d[1];
        end
    end

    // Command FSM with registered latch-drive outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pcnt_q     <= 4'd0;
            cmd_set_q  <= 1'b0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            enable_q   <= 1'b0;
            busy_q     <= 1'b0;
            conflict_q <= 1'b0;
            q_mirror_q <= 1'b0;
            q_valid_q  <= 1'b0;
        end else begin
            conflict_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pend_q == 2'b11) begin
                        conflict_q <= 1'b1;
                    end else if (pend_q != 2'b00) begin
                        cmd_set_q <= pend_q[0];
                        s_q       <= pend_q[0];
                        r_q       <= ~pend_q[0];
                        enable_q  <= 1'b1;
                        busy_q    <= 1'b1;
                        pcnt_q    <= PULSE_LOAD;
                        state_q   <= ST_DRIVE;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_DRIVE: begin
                    if (pcnt_q == 4'd0) begin
                        s_q        <= 1'b0;
                        r_q        <= 1'b0;
                        enable_q   <= 1'b0;
                        q_mirror_q <= cmd_set_q;
                        q_valid_q  <= 1'b1;
                        state_q    <= ST_GAP;
                    end else begin
                        pcnt_q <= pcnt_q - 4'd1;
                    end
                end
                ST_GAP: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    s_q      <= 1'b0;
                    r_q      <= 1'b0;
                    enable_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign s        = s_q;
    assign r        = r_q;
    assign enable   = enable_q;
    assign busy     = busy_q;
    assign conflict = conflict_q;
    assign q_mirror = q_mirror_q;
    assign q_valid  = q_valid_q;

endmodule

// File: tb/tb_sr_cmd_driver.sv
// Directed self-checking bench for sr_cmd_driver: a default instance and a
// DEB_CYCLES=1 / PULSE_LEN=1 instance, sampled 1 ns after each rising edge.
module tb_sr_cmd_driver;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic set_a = 1'b0, rst_a = 1'b0;
    logic set_b = 1'b0, rst_b = 1'b0;
    logic s_a, r_a, en_a, busy_a, conf_a, qm_a, qv_a;
    logic s_b, r_b, en_b, busy_b, conf_b, qm_b, qv_b;
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    sr_cmd_driver #(.DEB_CYCLES(4), .PULSE_LEN(2)) u_a (
        .clk(clk), .rst_n(rst_n), .set_btn(set_a), .reset_btn(rst_a),
        .s(s_a), .r(r_a), .enable(en_a), .busy(busy_a), .conflict(conf_a),
        .q_mirror(qm_a), .q_valid(qv_a)
    );

    sr_cmd_driver #(.DEB_CYCLES(1), .PULSE_LEN(1)) u_b (
        .clk(clk), .rst_n(rst_n), .set_btn(set_b), .reset_btn(rst_b),
        .s(s_b), .r(r_b), .enable(en_b), .busy(busy_b), .conflict(conf_b),
        .q_mirror(qm_b), .q_valid(qv_b)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    // Advance one edge, sample 1 ns later, and check the latch-safety invariants.
    task automatic step();
        @(posedge clk);
        #1;
        chk("a_s_and_r", s_a & r_a, 1'b0);
        chk("a_sel_no_en", (s_a | r_a) & ~en_a, 1'b0);
    endtask

    task automatic idle_steps(input int k);
        for (int j = 0; j < k; j++) step();
    endtask

    initial begin
        // Reset state of both instances.
        rst_n = 1'b0;
        idle_steps(3);
        chk("rst_s", s_a, 1'b0);   chk("rst_r", r_a, 1'b0);
        chk("rst_en", en_a, 1'b0); chk("rst_busy", busy_a, 1'b0);
        chk("rst_conf", conf_a, 1'b0); chk("rst_qm", qm_a, 1'b0);
        chk("rst_qv", qv_a, 1'b0);
        chk("rst_b_en", en_b, 1'b0); chk("rst_b_qv", qv_b, 1'b0);
        rst_n = 1'b1;
        idle_steps(2);

        // Simultaneous set/reset press: single conflict pulse, no drive.
        set_a = 1'b1; rst_a = 1'b1;
        for (int i = 0; i <= 12; i++) begin
            step();
            chk("cf_conflict", conf_a, (i == 7) ? 1'b1 : 1'b0);
            chk("cf_en", en_a, 1'b0);
            chk("cf_s", s_a, 1'b0);
            chk("cf_r", r_a, 1'b0);
            chk("cf_qv", qv_a, 1'b0);
        end
        set_a = 1'b0; rst_a = 1'b0;
        idle_steps(12);
        chk("cf_after_qv", qv_a, 1'b0);

        // Clean held set press: s/enable at edge 7 for two cycles.
        set_a = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            step();
            chk("set_s", s_a, (i == 7 || i == 8) ? 1'b1 : 1'b0);
            chk("set_en", en_a, (i == 7 || i == 8) ? 1'b1 : 1'b0);
            chk("set_r", r_a, 1'b0);
            chk("set_busy", busy_a, (i >= 7 && i <= 9) ? 1'b1 : 1'b0);
            chk("set_qm", qm_a, (i >= 9) ? 1'b1 : 1'b0);
            chk("set_qv", qv_a, (i >= 9) ? 1'b1 : 1'b0);
        end
        set_a = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("release_en", en_a, 1'b0);
        end

        // Bouncy reset button 1/0/1/0 then held: exactly one two-cycle r pulse.
        for (int i = 0; i <= 16; i++) begin
            rst_a = (i == 1 || i == 3) ? 1'b0 : 1'b1;
            step();
            chk("bnc_r", r_a, (i == 11 || i == 12) ? 1'b1 : 1'b0);
            chk("bnc_en", en_a, (i == 11 || i == 12) ? 1'b1 : 1'b0);
            chk("bnc_s", s_a, 1'b0);
            chk("bnc_qm", qm_a, (i >= 13) ? 1'b0 : 1'b1);
        end
        rst_a = 1'b0;
        idle_steps(12);

        // Set press, then reset press whose pending flag sets during DRIVE.
        for (int i = 0; i <= 16; i++) begin
            set_a = 1'b1;
            rst_a = (i >= 2) ? 1'b1 : 1'b0;
            step();
            chk("b2b_s", s_a, (i == 7 || i == 8) ? 1'b1 : 1'b0);
            chk("b2b_r", r_a, (i == 11 || i == 12) ? 1'b1 : 1'b0);
            chk("b2b_en", en_a, (i == 7 || i == 8 || i == 11 || i == 12) ? 1'b1 : 1'b0);
            chk("b2b_busy", busy_a, ((i >= 7 && i <= 9) || (i >= 11 && i <= 13)) ? 1'b1 : 1'b0);
            chk("b2b_qm", qm_a, (i >= 9 && i <= 12) ? 1'b1 : 1'b0);
            chk("b2b_conf", conf_a, 1'b0);
        end
        set_a = 1'b0; rst_a = 1'b0;
        idle_steps(14);

        // Reset during the second DRIVE cycle with set held through reset.
        set_a = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            step();
            chk("mr_s", s_a, (i == 7 || i == 8) ? 1'b1 : 1'b0);
        end
        rst_n = 1'b0;
        step();
        chk("mr_s0", s_a, 1'b0);     chk("mr_en0", en_a, 1'b0);
        chk("mr_busy0", busy_a, 1'b0); chk("mr_qm0", qm_a, 1'b0);
        chk("mr_qv0", qv_a, 1'b0);
        rst_n = 1'b1;
        for (int i = 10; i <= 18; i++) begin
            step();
            chk("mr_again_s", s_a, (i == 17 || i == 18) ? 1'b1 : 1'b0);
            chk("mr_again_qv", qv_a, 1'b0);
        end
        set_a = 1'b0;
        idle_steps(12);

        // Fast instance: 4-edge latency and single-cycle enable.
        set_b = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            step();
            chk("fast_s", s_b, (i == 4) ? 1'b1 : 1'b0);
            chk("fast_en", en_b, (i == 4) ? 1'b1 : 1'b0);
            chk("fast_r", r_b, 1'b0);
            chk("fast_busy", busy_b, (i == 4 || i == 5) ? 1'b1 : 1'b0);
            chk("fast_qm", qm_b, (i >= 5) ? 1'b1 : 1'b0);
            chk("fast_qv", qv_b, (i >= 5) ? 1'b1 : 1'b0);
        end
        set_b = 1'b0;
        idle_steps(4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sr_cmd_driver.md
# sr_cmd_driver

Upstream control stage for the SR latch. Takes two raw, bouncy push-button inputs (set, reset), synchronises and debounces them, and turns each debounced press into a clean, time-bounded drive pulse on the latch's `s`, `r` and `enable` inputs. It guarantees the latch never sees the illegal `s=r=1` combination. It also keeps a registered mirror of the value the latch holds.

## Interface
Parameters:
- `DEB_CYCLES`, default 4: consecutive synchronised samples a button must differ from its debounced level before that level flips. Legal range is 1..255.
- `PULSE_LEN`, default 2: cycles `enable` and the selected `s`/`r` stay high per command. Legal range is 1..15.

Ports:
- `clk`: input, 1 bit. Single clock; all logic on the rising edge.
- `rst_n`: input, 1 bit. Reset, synchronous, active-low.
- `set_btn`: input, 1 bit. Raw set button, asynchronous and bouncy.
- `reset_btn`: input, 1 bit. Raw reset button, asynchronous and bouncy.
- `s`: output, 1 bit, registered. Latch set input.
- `r`: output, 1 bit, registered. Latch reset input.
- `enable`: output, 1 bit, registered. Latch enable.
- `busy`: output, 1 bit, registered. High while the FSM is not in IDLE.
- `conflict`: output, 1 bit, registered. One-cycle pulse when set and reset are presented together.
- `q_mirror`: output, 1 bit, registered. The value the latch holds after the last completed command.
- `q_valid`: output, 1 bit, registered. 0 until the first command completes after reset, then 1.

## Operation
Input path, per button:
- Two-flop synchroniser, giving `sync`.
- Debounce counter, 8 bits:
  - When `sync` equals the debounced level `deb`, the counter clears.
  - Otherwise it increments.
  - When an increment would make it equal `DEB_CYCLES`, `deb` takes `sync` and the counter clears.
- Rising-edge detect on `deb` raises a one-deep pending request flag (`pend_set` or `pend_rst`).
- A falling edge of `deb` (button release) generates nothing.
- A request arriving while its flag is already set is absorbed, with no queueing beyond depth one.

FSM states:
- IDLE:
  - If both pending flags are set: pulse `conflict`, clear both flags, stay in IDLE, and drive nothing.
  - Otherwise, if one flag is set: capture the command (set or reset), clear that flag, go to DRIVE, and load the pulse counter.
- DRIVE:
  - `enable=1`, with `s=1` for a set command or `r=1` for a reset command. The other select stays 0.
  - This lasts exactly `PULSE_LEN` cycles, then the FSM goes to GAP.
- GAP:
  - One cycle with `s=r=enable=0`.
  - On entry, `q_mirror` takes 1 for a set command or 0 for a reset command, and `q_valid` goes to 1.
  - The FSM then returns to IDLE.
- Presses that occur during DRIVE or GAP are held in the pending flags and serviced from IDLE. A set flag and a reset flag both pending at IDLE counts as a conflict, even if the presses happened at different times.

Invariant: `s & r` is never 1. `s` or `r` is high only while `enable` is high.

`busy` is 1 in DRIVE and GAP, and 0 in IDLE.

## Timing
Reset (`rst_n=0` sampled at a rising edge) clears all of the following at that edge:
- `s`, `r`, `enable`, `busy`, `conflict`, `q_mirror`, `q_valid` all go to 0.
- Synchronisers, `deb`, debounce counters and pending flags clear.
- The FSM returns to IDLE.

Reset applied mid-DRIVE drops `s`/`r`/`enable` at that same edge and leaves `q_mirror` unchanged at 0.

A button held through reset is seen as a new press once debounced after reset.

Press latency, with a raw button first high at edge n and held:
- Edge n+1: `sync` goes high.
- Edge n+1+`DEB_CYCLES`: `deb` goes high.
- Edge n+2+`DEB_CYCLES`: the pending flag is set.
- Edge n+3+`DEB_CYCLES`: `s` (or `r`) and `enable` go high, and `busy` goes high.
- `DEB_CYCLES=4` gives 7 edges.

Drive timing:
- `s`/`enable` fall after `PULSE_LEN` cycles high.
- `q_mirror` updates at the same edge.
- `busy` falls one edge later.

A glitch shorter than `DEB_CYCLES` synchronised samples produces no `deb` change and no command.

Back-to-back commands have a minimum spacing from one `enable` rise to the next of `PULSE_LEN+2` cycles (DRIVE, GAP, IDLE).

`conflict` pulses one cycle after the IDLE evaluation edge and never coincides with `enable=1` from a new command.

## Test plan
- Reset then hold `set_btn=1` with defaults: `s=1` and `enable=1` at edge 7 for 2 cycles, `r=0` throughout; after that `q_mirror=1`, `q_valid=1`, and `busy` is high for 3 cycles.
- Bouncy `reset_btn` toggling 1/0/1/0 each cycle for 3 cycles, then held at 1: no drive during the bounce; exactly one `r` pulse of 2 cycles; then `q_mirror=0`.
- `set_btn` and `reset_btn` rise on the same cycle: `conflict` pulses once; `s`, `r` and `enable` stay 0; `q_valid` stays 0.
- `set_btn` press; then a `reset_btn` press whose pending flag sets during DRIVE: the set pulse completes, then after the GAP and IDLE cycles an `r` pulse follows; final `q_mirror=0`; `s&r` is never 1.
- `rst_n` driven low during the second DRIVE cycle: at that edge `s`, `enable`, `busy`, `q_mirror` and `q_valid` are 0; no command appears until a fresh debounced press.
- With `DEB_CYCLES=1` and `PULSE_LEN=1`: a press-to-`s` latency of 4 edges, and a single-cycle `enable`.
